// File: rtl/calc_entry_fsm.sv
// Calculator entry/control FSM: builds two decimal operands from keypad events,
// latches the operator and computes A+B or A-B. The all-clear key is built in when CALC_CLEAR_EN is defined.
module calc_entry_fsm #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_press,
    input  logic           is_num,
    input  logic           is_op,
    input  logic           is_eq,
    input  logic [3:0]     num_val,
    input  logic [1:0]     op_val,
    output logic [W-1:0]   operand_a,
    output logic [W-1:0]   operand_b,
    output logic [1:0]     op_sel,
    output logic [W+1:0]   result,
    output logic           result_valid,
    output logic [1:0]     state,
    output logic [W+1:0]   disp_val
);

    localparam int unsigned MAXV = (10 ** DIGITS) - 1;
    localparam int unsigned CW   = $clog2(DIGITS + 1);
    localparam int unsigned RW   = W + 2;
    localparam int unsigned MW   = W + 4;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;
    logic [1:0]      op_q, op_d;
    logic [RW-1:0]   res_q, res_d;
    logic            rv_q, rv_d;
    logic [RW-1:0]   disp_q, disp_d;
    logic            press_q;

    logic            ev;
    logic            k_eq, k_op, k_num;
    logic            op_ok, num_ok, chain_ok;
    logic [MW-1:0]   acc_a, acc_b;
    logic [RW-1:0]   sum, diff;

    // Next-state and datapath decode; one key event is acted on per press
    always_comb begin
        ev       = btn_press & ~press_q;
        k_eq     = ev & is_eq;
        k_op     = ev & ~is_eq & is_op;
        k_num    = ev & ~is_eq & ~is_op & is_num;
        op_ok    = (op_val == 2'd1) || (op_val == 2'd2);
        num_ok   = (num_val <= 4'd9);
        acc_a    = MW'(a_q) * MW'(10) + MW'(num_val);
        acc_b    = MW'(b_q) * MW'(10) + MW'(num_val);
        sum      = RW'(a_q) + RW'(b_q);
        diff     = RW'(a_q) - RW'(b_q);
        chain_ok = ~res_q[RW-1] && (res_q <= RW'(MAXV));

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        op_d     = op_q;
        res_d    = res_q;
        rv_d     = 1'b0;

        case (state_q)
            S_A: begin
                if (k_op && op_ok) begin
                    op_d    = op_val;
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = S_B;
                end else if (k_num && num_ok && (cnt_a_q < CW'(DIGITS))) begin
                    a_d     = W'(acc_a);
                    cnt_a_d = cnt_a_q + CW'(1);
                end
            end
            S_B: begin
                if (k_eq) begin
                    res_d   = (op_q == 2'd2) ? diff : sum;
                    rv_d    = 1'b1;
                    state_d = S_RES;
                end else if (k_op && op_ok) begin
                    op_d = op_val;
                end else if (k_num && num_ok && (cnt_b_q < CW'(DIGITS))) begin
                    b_d     = W'(acc_b);
                    cnt_b_d = cnt_b_q + CW'(1);
                end
            end
            S_RES: begin
                if (k_op && op_ok && chain_ok) begin
                    a_d     = W'(res_q);
                    cnt_a_d = CW'(DIGITS);
                    op_d    = op_val;
                    b_d     = '0;
                    cnt_b_d = '0;
                    state_d = S_B;
                end else if (k_num && num_ok) begin
                    a_d     = W'(num_val);
                    cnt_a_d = CW'(1);
                    b_d     = '0;
                    op_d    = 2'd0;
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase

`ifdef CALC_CLEAR_EN
        if (k_op && (op_val == 2'd3)) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = 2'd0;
            res_d   = '0;
            rv_d    = 1'b0;
        end
`endif

        // Display tracks the value the user is currently looking at
        case (state_d)
            S_A:     disp_d = RW'(a_d);
            S_B:     disp_d = (cnt_b_d != '0) ? RW'(b_d) : RW'(a_d);
            S_RES:   disp_d = res_d;
            default: disp_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            op_q    <= 2'd0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            disp_q  <= '0;
            press_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            disp_q  <= disp_d;
            press_q <= btn_press;
        end
    end

    assign operand_a    = a_q;
    assign operand_b    = b_q;
    assign op_sel       = op_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign state        = state_q;
    assign disp_val     = disp_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm; results are scoreboarded against result_valid pulses.
module tb_calc_entry_fsm;

    localparam int unsigned W  = 10;
    localparam int unsigned RW = W + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_press;
    logic          is_num, is_op, is_eq;
    logic [3:0]    num_val;
    logic [1:0]    op_val;
    logic [W-1:0]  operand_a, operand_b;
    logic [1:0]    op_sel;
    logic [RW-1:0] result;
    logic          result_valid;
    logic [1:0]    state;
    logic [RW-1:0] disp_val;

    int total   = 0;
    int bad     = 0;
    int rv_seen = 0;
    int rv_exp  = 0;
    logic [RW-1:0] sb[$];

    calc_entry_fsm #(.DIGITS(3), .W(W)) dut (
        .clk(clk), .rst(rst), .btn_press(btn_press),
        .is_num(is_num), .is_op(is_op), .is_eq(is_eq),
        .num_val(num_val), .op_val(op_val),
        .operand_a(operand_a), .operand_b(operand_b), .op_sel(op_sel),
        .result(result), .result_valid(result_valid), .state(state),
        .disp_val(disp_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every result_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            rv_seen++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("sb_result", 32'(result), 32'(sb.pop_front()));
        end
    end

    task automatic key(input logic n, input logic o, input logic e,
                       input logic [3:0] nv, input logic [1:0] ov);
        @(negedge clk);
        is_num = n; is_op = o; is_eq = e; num_val = nv; op_val = ov;
        btn_press = 1'b1;
        @(negedge clk);
        btn_press = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        num_val = 4'd0; op_val = 2'd0;
    endtask

    task automatic num(input logic [3:0] v); key(1'b1, 1'b0, 1'b0, v, 2'd0); endtask
    task automatic op(input logic [1:0] v);  key(1'b0, 1'b1, 1'b0, 4'd0, v); endtask
    task automatic eq();                     key(1'b0, 1'b0, 1'b1, 4'd0, 2'd0); endtask

    task automatic expect_res(input logic [RW-1:0] r);
        sb.push_back(r);
        rv_exp++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"},     32'(operand_a),    32'd0);
        chk({tag, "_b"},     32'(operand_b),    32'd0);
        chk({tag, "_op"},    32'(op_sel),       32'd0);
        chk({tag, "_res"},   32'(result),       32'd0);
        chk({tag, "_rv"},    32'(result_valid), 32'd0);
        chk({tag, "_state"}, 32'(state),        32'd0);
        chk({tag, "_disp"},  32'(disp_val),     32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Key held through reset release must not create an event
        rst = 1'b1; btn_press = 1'b1; is_num = 1'b1; is_op = 1'b0; is_eq = 1'b0;
        num_val = 4'd4; op_val = 2'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_rel_a", 32'(operand_a), 32'd0);
        chk("held_rel_state", 32'(state), 32'd0);
        btn_press = 1'b0; is_num = 1'b0; num_val = 4'd0;

        // 12 + 3 = 15
        num(4'd1); num(4'd2);
        chk("a_12", 32'(operand_a), 32'd12);
        chk("disp_12", 32'(disp_val), 32'd12);
        op(2'd1);
        chk("state_b", 32'(state), 32'd1);
        chk("disp_b_empty", 32'(disp_val), 32'd12);
        num(4'd3);
        chk("disp_b3", 32'(disp_val), 32'd3);
        expect_res(12'd15);
        eq();
        chk("rv_on", 32'(result_valid), 32'd1);
        chk("res_15", 32'(result), 32'd15);
        chk("a_final", 32'(operand_a), 32'd12);
        chk("b_final", 32'(operand_b), 32'd3);
        chk("state_res", 32'(state), 32'd2);
        @(negedge clk);
        chk("rv_off", 32'(result_valid), 32'd0);
        eq();
        chk("eq_in_res_state", 32'(state), 32'd2);

        // 5 - 9 = -4, then a chained '+' on a negative result is rejected
        num(4'd5);
        chk("new_a", 32'(operand_a), 32'd5);
        chk("new_op", 32'(op_sel), 32'd0);
        op(2'd2); num(4'd9);
        expect_res(12'hFFC);
        eq();
        chk("res_neg4", 32'(result), 32'hFFC);
        chk("disp_neg4", 32'(disp_val), 32'hFFC);
        op(2'd1);
        chk("neg_chain_state", 32'(state), 32'd2);
        chk("neg_chain_op", 32'(op_sel), 32'd2);

        // Digit limit and out-of-range chaining
        num(4'd9); num(4'd9); num(4'd9); num(4'd7);
        chk("a_999", 32'(operand_a), 32'd999);
        op(2'd1); num(4'd1);
        expect_res(12'd1000);
        eq();
        chk("res_1000", 32'(result), 32'd1000);
        op(2'd2);
        chk("big_chain_state", 32'(state), 32'd2);

        // Chaining: 2+3=5, +4=9, then a digit starts over
        num(4'd2); op(2'd1); num(4'd3);
        expect_res(12'd5);
        eq();
        op(2'd1);
        chk("chain_state", 32'(state), 32'd1);
        chk("chain_a", 32'(operand_a), 32'd5);
        chk("chain_b", 32'(operand_b), 32'd0);
        chk("chain_disp", 32'(disp_val), 32'd5);
        num(4'd4);
        expect_res(12'd9);
        eq();
        chk("chain_res", 32'(result), 32'd9);
        num(4'd7);
        chk("restart_state", 32'(state), 32'd0);
        chk("restart_a", 32'(operand_a), 32'd7);
        chk("restart_op", 32'(op_sel), 32'd0);

        // Held key produces one accumulation
        pulse_reset();
        @(negedge clk);
        btn_press = 1'b1; is_num = 1'b1; num_val = 4'd4;
        repeat (20) @(negedge clk);
        chk("hold_a", 32'(operand_a), 32'd4);
        btn_press = 1'b0; is_num = 1'b0; num_val = 4'd0;

        // Ignored keys in S_A: '=', reserved op 0, digit > 9
        eq();
        chk("eq_in_a", 32'(state), 32'd0);
        op(2'd0);
        chk("op0_in_a", 32'(state), 32'd0);
        num(4'd12);
        chk("digit12_a", 32'(operand_a), 32'd4);
        key(1'b1, 1'b1, 1'b0, 4'd1, 2'd2);
        chk("prio_op_state", 32'(state), 32'd1);
        chk("prio_op_a", 32'(operand_a), 32'd4);

        // Reset in S_B with a pending '=' event
        pulse_reset();
        num(4'd8); op(2'd1); num(4'd6);
        chk("rst_pre_b", 32'(operand_b), 32'd6);
        @(negedge clk);
        rst = 1'b1; btn_press = 1'b1; is_eq = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_rel_state", 32'(state), 32'd0);
        btn_press = 1'b0; is_eq = 1'b0;

`ifdef CALC_CLEAR_EN
        num(4'd1); op(2'd1); num(4'd2);
        expect_res(12'd3);
        eq();
        op(2'd3);
        check_zero("clear");
`else
        num(4'd5); op(2'd3);
        chk("op3_state", 32'(state), 32'd0);
        chk("op3_op", 32'(op_sel), 32'd0);
        chk("op3_a", 32'(operand_a), 32'd5);
`endif

        repeat (2) @(negedge clk);
        chk("rv_count", 32'(rv_seen), 32'(rv_exp));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
